// File: rtl/hdr_recover_dispatcher.sv
// hdr_recover_dispatcher: walks every pixel of a frame, fetches its exposure
// bytes from the image buffer, runs them through the HDR recover engine and
// writes the engine result to the output frame buffer at the same address.
module hdr_recover_dispatcher #(
    parameter int unsigned IMAGE_NUMBER = 4,
    parameter int unsigned PIXEL_COUNT  = 1024,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      error,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [IMAGE_NUMBER*8-1:0] rd_data,
    output logic                      calculate_start,
    output logic [IMAGE_NUMBER*8-1:0] images,
    input  logic                      calculate_finish,
    input  logic [7:0]                calculate_result,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data
);

    localparam int unsigned DATA_W = IMAGE_NUMBER * 8;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_READ  = 3'd1;
    localparam logic [ST_W-1:0] S_LATCH = 3'd2;
    localparam logic [ST_W-1:0] S_ISSUE = 3'd3;
    localparam logic [ST_W-1:0] S_WAIT  = 3'd4;
    localparam logic [ST_W-1:0] S_WRITE = 3'd5;
    localparam logic [ST_W-1:0] S_DONE  = 3'd6;

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_next_state;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [DATA_W-1:0] r_images;
    logic [7:0]        r_wr_data;
    logic              r_error;
    logic              r_busy;
    logic              r_rd_en;
    logic              r_calc_start;
    logic              r_wr_en;
    logic              r_frame_done;
    logic              w_last_pix;
    logic              w_wait_expired;

    assign w_last_pix     = (r_pix_cnt == ADDR_W'(PIXEL_COUNT - 1));
    assign w_wait_expired = (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; an engine finish beats a coincident timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (frame_start) w_next_state = S_READ;
            S_READ:  w_next_state = S_LATCH;
            S_LATCH: w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (calculate_finish) begin
                    w_next_state = S_WRITE;
                end else if (w_wait_expired) begin
                    w_next_state = S_DONE;
                end
            end
            S_WRITE: w_next_state = w_last_pix ? S_DONE : S_READ;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Pixel/wait counters, operand latch, result capture and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_wait_cnt <= '0;
            r_images   <= '0;
            r_wr_data  <= '0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_error   <= 1'b0;
                        r_pix_cnt <= '0;
                    end
                end
                S_LATCH: r_images   <= rd_data;
                S_ISSUE: r_wait_cnt <= '0;
                S_WAIT: begin
                    if (calculate_finish) begin
                        r_wr_data <= calculate_result;
                    end else if (w_wait_expired) begin
                        r_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!w_last_pix) begin
                        r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes registered from the next state so they align with the state they decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_calc_start <= 1'b0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_busy       <= (w_next_state != S_IDLE);
            r_rd_en      <= (w_next_state == S_READ);
            r_calc_start <= (w_next_state == S_ISSUE);
            r_wr_en      <= (w_next_state == S_WRITE);
            r_frame_done <= (w_next_state == S_DONE);
        end
    end

    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign error           = r_error;
    assign rd_en           = r_rd_en;
    assign rd_addr         = r_pix_cnt;
    assign calculate_start = r_calc_start;
    assign images          = r_images;
    assign wr_en           = r_wr_en;
    assign wr_addr         = r_pix_cnt;
    assign wr_data         = r_wr_data;

endmodule

// File: tb/tb_hdr_recover_dispatcher.sv
// Directed bench for hdr_recover_dispatcher with a 4-pixel frame and a
// behavioural image buffer / recover engine (result = mean of the four lanes).
module tb_hdr_recover_dispatcher;

    localparam int unsigned IMG = 4;
    localparam int unsigned PIX = 4;
    localparam int unsigned AW  = 2;
    localparam int unsigned TO  = 15;
    localparam logic [31:0] PAT = {8'd80, 8'd40, 8'd20, 8'd10};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          busy;
    logic          frame_done;
    logic          error;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data = '0;
    logic          calculate_start;
    logic [31:0]   images;
    logic          calculate_finish = 1'b0;
    logic [7:0]    calculate_result = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    always #5 clk = ~clk;

    hdr_recover_dispatcher #(
        .IMAGE_NUMBER(IMG),
        .PIXEL_COUNT (PIX),
        .ADDR_W      (AW),
        .TIMEOUT     (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .busy            (busy),
        .frame_done      (frame_done),
        .error           (error),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .calculate_start (calculate_start),
        .images          (images),
        .calculate_finish(calculate_finish),
        .calculate_result(calculate_result),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
    );

    int total = 0;
    int bad   = 0;

    // Monitor/model state (written only by the negedge process)
    int          cyc       = 0;
    int          start_cnt = 0;
    int          wr_cnt    = 0;
    int          wr_bad    = 0;
    int          img_bad   = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          eng_cnt   = 0;
    int          eng_sum   = 0;
    int          rd_hold   = 0;
    logic [31:0] img_ref   = '0;
    logic [AW-1:0] exp_addr = '0;

    // Stimulus-side state (written only by the main process)
    int eng_delay = 2;
    int base      = 0;
    int s_start, s_wr, s_wrbad, s_img, s_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Observe DUT outputs, then advance the engine and image-buffer models
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            eng_cnt          = 0;
            calculate_finish = 1'b0;
            calculate_result = '0;
            rd_data          = '0;
            rd_hold          = 0;
            exp_addr         = '0;
        end else begin
            if (!busy) exp_addr = '0;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (eng_cnt != 0 && images != img_ref) img_bad++;
            if (calculate_start) begin
                start_cnt++;
                img_ref = images;
                if (images != PAT) img_bad++;
            end
            if (wr_en) begin
                wr_cnt++;
                if (wr_addr != exp_addr || wr_data != 8'd37) wr_bad++;
                exp_addr = exp_addr + AW'(1);
            end
            calculate_finish = 1'b0;
            if (eng_cnt != 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_sum = int'(img_ref[7:0]) + int'(img_ref[15:8])
                            + int'(img_ref[23:16]) + int'(img_ref[31:24]);
                    calculate_finish = 1'b1;
                    calculate_result = 8'(eng_sum >> 2);
                end
            end
            if (calculate_start && eng_delay != 0) eng_cnt = eng_delay;
            if (rd_en) begin
                rd_data = PAT;
                rd_hold = 2;
            end else if (rd_hold != 0) begin
                rd_hold--;
                if (rd_hold == 0) rd_data = '0;
            end
        end
    end

    task automatic snapshot();
        s_start = start_cnt;
        s_wr    = wr_cnt;
        s_wrbad = wr_bad;
        s_img   = img_bad;
        s_done  = done_cnt;
    endtask

    task automatic start_frame(input int delay, input bit hold);
        eng_delay = delay;
        snapshot();
        @(posedge clk); #1;
        frame_start = 1'b1;
        base = cyc;
        if (!hold) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == s_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        frame_start = 1'b0;
        check("frame_done_seen", 32'(done_cnt - s_done), 1);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy), 0);
        check("rst_rd_en",  32'(rd_en), 0);
        check("rst_cstart", 32'(calculate_start), 0);
        check("rst_wr_en",  32'(wr_en), 0);
        check("rst_done",   32'(frame_done), 0);
        check("rst_error",  32'(error), 0);
        check("rst_images", images, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Normal frame, 2-cycle engine
        start_frame(2, 1'b0);
        check("n_busy", 32'(busy), 1);
        wait_done(200);
        check("n_done_cycle", 32'(done_cyc - base - 1), 25);
        check("n_starts", 32'(start_cnt - s_start), 4);
        check("n_writes", 32'(wr_cnt - s_wr), 4);
        check("n_wr_bad", 32'(wr_bad - s_wrbad), 0);
        check("n_img_bad", 32'(img_bad - s_img), 0);
        check("n_error", 32'(error), 0);
        check("n_idle", 32'(busy), 0);

        // Engine stalls 7 cycles per pixel
        start_frame(7, 1'b0);
        wait_done(300);
        check("s_writes", 32'(wr_cnt - s_wr), 4);
        check("s_wr_bad", 32'(wr_bad - s_wrbad), 0);
        check("s_img_bad", 32'(img_bad - s_img), 0);
        check("s_error", 32'(error), 0);
        check("s_done_cycle", 32'(done_cyc - base - 1), 4 * 11 + 1);

        // Engine never finishes: abort after TIMEOUT wait cycles
        start_frame(0, 1'b0);
        wait_done(200);
        check("t_done_cycle", 32'(done_cyc - base - 1), 19);
        check("t_error", 32'(error), 1);
        check("t_writes", 32'(wr_cnt - s_wr), 0);
        check("t_starts", 32'(start_cnt - s_start), 1);

        // Next accepted frame clears the error
        start_frame(2, 1'b0);
        check("c_error_cleared", 32'(error), 0);
        wait_done(200);
        check("c_writes", 32'(wr_cnt - s_wr), 4);

        // frame_start held high through a whole frame
        start_frame(2, 1'b1);
        wait_done(200);
        repeat (10) @(posedge clk);
        #1;
        check("h_frames", 32'(done_cnt - s_done), 1);
        check("h_writes", 32'(wr_cnt - s_wr), 4);
        check("h_idle", 32'(busy), 0);

        // Reset during S_WAIT of pixel 2
        start_frame(7, 1'b0);
        n = 0;
        while (start_cnt - s_start < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("m_starts", 32'(start_cnt - s_start), 3);
        check("m_writes", 32'(wr_cnt - s_wr), 2);
        rst_n = 1'b0;
        #1;
        check("m_busy",   32'(busy), 0);
        check("m_cstart", 32'(calculate_start), 0);
        check("m_wr_en",  32'(wr_en), 0);
        check("m_rd_en",  32'(rd_en), 0);
        check("m_images", images, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("m_no_done", 32'(done_cnt - s_done), 0);
        start_frame(2, 1'b0);
        wait_done(200);
        check("r_writes", 32'(wr_cnt - s_wr), 4);
        check("r_wr_bad", 32'(wr_bad - s_wrbad), 0);
        check("r_done_cycle", 32'(done_cyc - base - 1), 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
